// File: rtl/vga_write_arbiter_pkg.sv
// Shared types and screen constants for the VGA write-port arbiter.
// Imported by the arbiter top; the sub-module stays parameter-only.
package vga_write_arbiter_pkg;

    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COLOUR_W = 3;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        GRANT_MAP    = 2'd1,
        GRANT_SPRITE = 2'd2,
        HANDOFF      = 2'd3
    } arb_state_t;

    typedef enum logic {
        MAP    = 1'b0,
        SPRITE = 1'b1
    } requester_t;

    function automatic requester_t other_requester(input requester_t r);
        return (r == MAP) ? SPRITE : MAP;
    endfunction

endpackage

// File: rtl/vga_write_arbiter_burst_watchdog.sv
// Burst watchdog: counts cycles while enabled and flags the cycle in which
// the count reaches MAX_BURST-1, so the owner can be forcibly released.
module burst_watchdog #(
    parameter int MAX_BURST = 131072
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] count;

    assign expire = enable && (count == LIMIT);

    // Holding at the limit keeps the counter from wrapping if the owner lingers.
    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Arbitrates the single VGA adapter write port between the map drawer and the
// sprite drawer, granting whole bursts and alternating under contention.
module vga_write_arbiter #(
    parameter int X_W       = vga_write_arbiter_pkg::X_W,
    parameter int Y_W       = vga_write_arbiter_pkg::Y_W,
    parameter int COLOUR_W  = vga_write_arbiter_pkg::COLOUR_W,
    parameter int MAX_BURST = 131072
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                map_req,
    input  logic                map_plot,
    input  logic [X_W-1:0]      map_x,
    input  logic [Y_W-1:0]      map_y,
    input  logic [COLOUR_W-1:0] map_colour,
    input  logic                map_done,
    input  logic                spr_req,
    input  logic                spr_plot,
    input  logic [X_W-1:0]      spr_x,
    input  logic [Y_W-1:0]      spr_y,
    input  logic [COLOUR_W-1:0] spr_colour,
    input  logic                spr_done,
    output logic                map_gnt,
    output logic                spr_gnt,
    output logic                vga_plot,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                redraw_done,
    output logic                timeout
);

    import vga_write_arbiter_pkg::*;

    arb_state_t state;
    arb_state_t next_state;
    requester_t last_served;
    requester_t next_last_served;

    logic map_owned;
    logic spr_owned;
    logic expire;
    logic set_timeout;

    assign map_owned = (state == GRANT_MAP);
    assign spr_owned = (state == GRANT_SPRITE);
    assign map_gnt   = map_owned;
    assign spr_gnt   = spr_owned;

    // Idle and handoff both clear the count, so every grant starts from zero.
    burst_watchdog #(
        .MAX_BURST(MAX_BURST)
    ) u_watchdog (
        .clock (clock),
        .resetn(resetn),
        .clear (!(map_owned || spr_owned)),
        .enable(map_owned || spr_owned),
        .expire(expire)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            last_served <= SPRITE;
        end else begin
            state       <= next_state;
            last_served <= next_last_served;
        end
    end

    // A done in the same cycle as expiry is treated as a normal completion.
    always_comb begin
        next_state       = state;
        next_last_served = last_served;
        set_timeout      = 1'b0;
        case (state)
            IDLE: begin
                if (map_req && spr_req) begin
                    next_state = (other_requester(last_served) == MAP) ? GRANT_MAP : GRANT_SPRITE;
                end else if (map_req) begin
                    next_state = GRANT_MAP;
                end else if (spr_req) begin
                    next_state = GRANT_SPRITE;
                end
            end
            GRANT_MAP: begin
                if (map_done) begin
                    next_state       = HANDOFF;
                    next_last_served = MAP;
                end else if (expire) begin
                    next_state       = HANDOFF;
                    next_last_served = MAP;
                    set_timeout      = 1'b1;
                end
            end
            GRANT_SPRITE: begin
                if (spr_done) begin
                    next_state       = HANDOFF;
                    next_last_served = SPRITE;
                end else if (expire) begin
                    next_state       = HANDOFF;
                    next_last_served = SPRITE;
                    set_timeout      = 1'b1;
                end
            end
            HANDOFF: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Coordinates hold their last value whenever nobody owns the port.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            vga_plot    <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            redraw_done <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            redraw_done <= map_owned && map_done;
            if (set_timeout) begin
                timeout <= 1'b1;
            end
            if (map_owned) begin
                vga_plot   <= map_plot;
                vga_x      <= map_x;
                vga_y      <= map_y;
                vga_colour <= map_colour;
            end else if (spr_owned) begin
                vga_plot   <= spr_plot;
                vga_x      <= spr_x;
                vga_y      <= spr_y;
                vga_colour <= spr_colour;
            end else begin
                vga_plot <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter with a shortened watchdog (MAX_BURST=16).
module tb_vga_write_arbiter;

    logic       clock;
    logic       resetn;
    logic       map_req;
    logic       map_plot;
    logic [8:0] map_x;
    logic [7:0] map_y;
    logic [2:0] map_colour;
    logic       map_done;
    logic       spr_req;
    logic       spr_plot;
    logic [8:0] spr_x;
    logic [7:0] spr_y;
    logic [2:0] spr_colour;
    logic       spr_done;
    logic       map_gnt;
    logic       spr_gnt;
    logic       vga_plot;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       redraw_done;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    vga_write_arbiter #(
        .MAX_BURST(16)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .map_req    (map_req),
        .map_plot   (map_plot),
        .map_x      (map_x),
        .map_y      (map_y),
        .map_colour (map_colour),
        .map_done   (map_done),
        .spr_req    (spr_req),
        .spr_plot   (spr_plot),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_colour (spr_colour),
        .spr_done   (spr_done),
        .map_gnt    (map_gnt),
        .spr_gnt    (spr_gnt),
        .vga_plot   (vga_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .redraw_done(redraw_done),
        .timeout    (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        map_req    = 1'b0;
        map_plot   = 1'b0;
        map_x      = '0;
        map_y      = '0;
        map_colour = '0;
        map_done   = 1'b0;
        spr_req    = 1'b0;
        spr_plot   = 1'b0;
        spr_x      = '0;
        spr_y      = '0;
        spr_colour = '0;
        spr_done   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({map_gnt, spr_gnt, vga_plot, redraw_done, timeout} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b expected 00000", {map_gnt, spr_gnt, vga_plot, redraw_done, timeout});
        end
        checks++;
        if ({vga_x, vga_y, vga_colour} !== 20'd0) begin
            errors++;
            $display("[TB] FAIL reset_coords got x=%0d y=%0d c=%0d expected 0", vga_x, vga_y, vga_colour);
        end
    endtask

    task automatic test_map_only();
        do_reset();
        map_req = 1'b1;
        checks++;
        if (map_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL map_gnt_before_edge got %b expected 0", map_gnt);
        end
        tick();
        checks++;
        if (map_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL map_gnt_rise got %b expected 1", map_gnt);
        end
        for (int i = 0; i < 4; i++) begin
            map_plot   = 1'b1;
            map_x      = 9'(10 + i);
            map_y      = 8'd20;
            map_colour = 3'b101;
            map_done   = (i == 3);
            tick();
            checks++;
            if (vga_plot !== 1'b1 || vga_x !== 9'(10 + i) || vga_y !== 8'd20 || vga_colour !== 3'b101) begin
                errors++;
                $display("[TB] FAIL map_pixel%0d got p=%b x=%0d y=%0d c=%0d expected p=1 x=%0d y=20 c=5",
                         i, vga_plot, vga_x, vga_y, vga_colour, 10 + i);
            end
            checks++;
            if (redraw_done !== (i == 3) || map_gnt !== (i != 3)) begin
                errors++;
                $display("[TB] FAIL map_ctrl%0d got done=%b gnt=%b expected done=%b gnt=%b",
                         i, redraw_done, map_gnt, i == 3, i != 3);
            end
        end
        clear_inputs();
        tick();
        checks++;
        if (redraw_done !== 1'b0 || vga_plot !== 1'b0 || vga_x !== 9'd13 || map_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL map_after got done=%b p=%b x=%0d gnt=%b expected 0 0 13 0",
                     redraw_done, vga_plot, vga_x, map_gnt);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        map_req = 1'b1;
        spr_req = 1'b1;
        tick();
        checks++;
        if (map_gnt !== 1'b1 || spr_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sim_first got map=%b spr=%b expected 1 0", map_gnt, spr_gnt);
        end
        map_done = 1'b1;
        tick();
        map_done = 1'b0;
        checks++;
        if (map_gnt !== 1'b0 || spr_gnt !== 1'b0 || redraw_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sim_handoff got map=%b spr=%b done=%b expected 0 0 1", map_gnt, spr_gnt, redraw_done);
        end
        tick();
        checks++;
        if (map_gnt !== 1'b0 || spr_gnt !== 1'b0 || redraw_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sim_idle got map=%b spr=%b done=%b expected 0 0 0", map_gnt, spr_gnt, redraw_done);
        end
        tick();
        checks++;
        if (map_gnt !== 1'b0 || spr_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sim_second got map=%b spr=%b expected 0 1", map_gnt, spr_gnt);
        end
        spr_done = 1'b1;
        tick();
        spr_done = 1'b0;
        checks++;
        if (spr_gnt !== 1'b0 || redraw_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sim_spr_handoff got spr=%b done=%b expected 0 0", spr_gnt, redraw_done);
        end
        tick();
        tick();
        checks++;
        if (map_gnt !== 1'b1 || spr_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sim_third got map=%b spr=%b expected 1 0", map_gnt, spr_gnt);
        end
        clear_inputs();
        map_done = 1'b1;
        tick();
        map_done = 1'b0;
        tick();
    endtask

    task automatic test_isolation();
        do_reset();
        spr_req = 1'b1;
        tick();
        spr_plot   = 1'b1;
        spr_x      = 9'd50;
        spr_y      = 8'd60;
        spr_colour = 3'b010;
        map_plot   = 1'b1;
        map_x      = 9'd300;
        map_y      = 8'd200;
        map_colour = 3'b111;
        map_done   = 1'b1;
        tick();
        map_done = 1'b0;
        checks++;
        if (vga_x !== 9'd50 || vga_y !== 8'd60 || vga_colour !== 3'b010 || spr_gnt !== 1'b1 || redraw_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL iso_first got x=%0d y=%0d c=%0d gnt=%b done=%b expected 50 60 2 1 0",
                     vga_x, vga_y, vga_colour, spr_gnt, redraw_done);
        end
        tick();
        checks++;
        if (vga_x !== 9'd50 || spr_gnt !== 1'b1 || map_gnt !== 1'b0 || redraw_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL iso_second got x=%0d spr=%b map=%b done=%b expected 50 1 0 0",
                     vga_x, spr_gnt, map_gnt, redraw_done);
        end
        spr_plot = 1'b0;
        tick();
        checks++;
        if (vga_plot !== 1'b0 || vga_x !== 9'd50) begin
            errors++;
            $display("[TB] FAIL iso_noplot got p=%b x=%0d expected 0 50", vga_plot, vga_x);
        end
        spr_done = 1'b1;
        tick();
        spr_done = 1'b0;
        checks++;
        if (redraw_done !== 1'b0 || spr_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL iso_end got done=%b spr=%b expected 0 0", redraw_done, spr_gnt);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_watchdog();
        // Done arriving exactly at the limit cycle must complete normally.
        do_reset();
        spr_req = 1'b1;
        tick();
        for (int k = 1; k < 16; k++) tick();
        checks++;
        if (spr_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wd_limit_gnt got %b expected 1", spr_gnt);
        end
        spr_done = 1'b1;
        tick();
        spr_done = 1'b0;
        checks++;
        if (spr_gnt !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wd_done_wins got gnt=%b timeout=%b expected 0 0", spr_gnt, timeout);
        end

        do_reset();
        spr_req = 1'b1;
        tick();
        map_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (spr_gnt !== 1'b1 || map_gnt !== 1'b0 || timeout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wd_hold%0d got spr=%b map=%b timeout=%b expected 1 0 0",
                         k, spr_gnt, map_gnt, timeout);
            end
            tick();
        end
        checks++;
        if (spr_gnt !== 1'b0 || timeout !== 1'b1 || redraw_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wd_expire got spr=%b timeout=%b done=%b expected 0 1 0", spr_gnt, timeout, redraw_done);
        end
        tick();
        tick();
        checks++;
        if (map_gnt !== 1'b1 || spr_gnt !== 1'b0 || timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wd_next_map got map=%b spr=%b timeout=%b expected 1 0 1", map_gnt, spr_gnt, timeout);
        end
        map_done = 1'b1;
        tick();
        map_done = 1'b0;
        checks++;
        if (redraw_done !== 1'b1 || timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wd_sticky got done=%b timeout=%b expected 1 1", redraw_done, timeout);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        map_req = 1'b1;
        tick();
        map_plot   = 1'b1;
        map_x      = 9'd1;
        map_y      = 8'd2;
        map_colour = 3'b111;
        tick();
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== 9'd1) begin
            errors++;
            $display("[TB] FAIL mid_plot got p=%b x=%0d expected 1 1", vga_plot, vga_x);
        end
        resetn   = 1'b0;
        map_done = 1'b1;
        tick();
        resetn   = 1'b1;
        map_done = 1'b0;
        map_plot = 1'b0;
        checks++;
        if ({map_gnt, spr_gnt, vga_plot, redraw_done, timeout} !== 5'b0 || {vga_x, vga_y, vga_colour} !== 20'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset got flags=%b x=%0d y=%0d c=%0d expected all 0",
                     {map_gnt, spr_gnt, vga_plot, redraw_done, timeout}, vga_x, vga_y, vga_colour);
        end
        tick();
        checks++;
        if (map_gnt !== 1'b1 || redraw_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_regrant got gnt=%b done=%b expected 1 0", map_gnt, redraw_done);
        end
        map_done = 1'b1;
        tick();
        map_done = 1'b0;
        checks++;
        if (redraw_done !== 1'b1 || map_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_complete got done=%b gnt=%b expected 1 0", redraw_done, map_gnt);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        test_reset();
        test_map_only();
        test_simultaneous();
        test_isolation();
        test_watchdog();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
